bcd_scan_display: RTL and testbench

- Downstream consumer of the 8-bit binary to 12-bit BCD converter; drives a 3-digit, common-anode, multiplexed 7-segment display.
- Captures a 12-bit BCD word on a load strobe and applies it at a frame boundary, so no digit ever shows a mix of old and new data.
- Scans the ones, tens and hundreds digits with a per-digit dwell counter and inserts one anti-ghosting blank cycle at the start of each digit.
- Blanks leading zeros when enabled and flags non-decimal nibbles.

---
 rtl/bcd_scan_display.sv | 232 +++++++++++++++++++++++
 tb/tb_bcd_scan_display.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// -----------------------------------------------------------------------------
// bcd_scan_display
//
// Drives a 3-digit, common-anode, multiplexed 7-segment display from a 12-bit
// BCD word. The word is captured into a pending register on a load strobe and
// promoted to the active register only at a frame boundary, which is the first
// cycle of the ones slot. A digit therefore never shows a mix of old and new
// data. Each digit slot is REFRESH_DIV cycles long. The first cycle of every
// slot is blanked to prevent ghosting between digits.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous, active-high reset
//   i_bcd_in    {hundreds[11:8], tens[7:4], ones[3:0]} BCD word
//   i_load      one-cycle strobe; captures i_bcd_in into the pending register
//   i_lz_blank  1 = blank leading zeros (sampled live every cycle)
//   o_an        digit enables, active-low; [0]=ones, [1]=tens, [2]=hundreds
//   o_seg       segments {g,f,e,d,c,b,a}, active-low
//   o_err       1 = at least one nibble of the active word is above 9
// -----------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_bcd_in,
    input  logic        i_load,
    input  logic        i_lz_blank,
    output logic [2:0]  o_an,
    output logic [6:0]  o_seg,
    output logic        o_err
);

    // Width of the dwell counter. REFRESH_DIV is at least 2, so CW is at least 1.
    localparam int            CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2
    } digit_t;

    // Convert a BCD nibble to an active-low 7-segment pattern.
    // Non-decimal nibbles are shown as a dash.
    function automatic logic [6:0] f_seg_encode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h3F;
        endcase
        return pat;
    endfunction

    // Return 1 when any nibble of the 12-bit word is not a decimal digit.
    function automatic logic f_word_bad(input logic [11:0] word);
        return (word[11:8] > 4'd9) || (word[7:4] > 4'd9) || (word[3:0] > 4'd9);
    endfunction

    // Scan state
    digit_t        r_digit;
    digit_t        w_digit_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // Data path state
    logic [11:0]   r_active;
    logic [11:0]   r_pending;
    logic          r_pend_valid;

    // Output registers
    logic [2:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_err;

    // Next-output values
    logic [2:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic [2:0]    w_an_sel;
    logic [3:0]    w_nib;
    logic          w_digit_blank;

    logic          w_slot_start;
    logic          w_slot_end;
    logic          w_frame_start;
    logic          w_hund_zero;
    logic          w_tens_zero;

    assign w_slot_start  = (r_cnt == '0);
    assign w_slot_end    = (r_cnt == CNT_LAST);
    assign w_frame_start = w_slot_start && (r_digit == DIG_ONES);

    // A nibble above 9 never compares equal to zero, so it is never blanked.
    assign w_hund_zero   = (r_active[11:8] == 4'd0);
    assign w_tens_zero   = (r_active[7:4]  == 4'd0);

    // Scan state register: dwell counter and digit index.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_digit <= DIG_ONES;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    // Scan next-state: count through the slot, then step to the next digit.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        if (w_slot_end) begin
            w_cnt_nxt = '0;
            case (r_digit)
                DIG_ONES:  w_digit_nxt = DIG_TENS;
                DIG_TENS:  w_digit_nxt = DIG_HUNDS;
                DIG_HUNDS: w_digit_nxt = DIG_ONES;
                default:   w_digit_nxt = DIG_ONES;
            endcase
        end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // Pending register: the last load before a frame boundary wins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= 12'h000;
        end else if (i_load) begin
            r_pending <= i_bcd_in;
        end else begin
            r_pending <= r_pending;
        end
    end

    // Pending-valid flag. A load on the boundary cycle keeps the flag set,
    // so that word is applied at the following boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_valid <= 1'b0;
        end else if (i_load) begin
            r_pend_valid <= 1'b1;
        end else if (w_frame_start) begin
            r_pend_valid <= 1'b0;
        end else begin
            r_pend_valid <= r_pend_valid;
        end
    end

    // Active word and error flag. Both change only at a frame boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active <= 12'h000;
            r_err    <= 1'b0;
        end else if (w_frame_start && r_pend_valid) begin
            r_active <= r_pending;
            r_err    <= f_word_bad(r_pending);
        end else begin
            r_active <= r_active;
            r_err    <= r_err;
        end
    end

    // Digit select: choose the nibble, the anode and the blanking for the
    // current slot.
    always_comb begin
        w_nib         = 4'd0;
        w_an_sel      = 3'b111;
        w_digit_blank = 1'b1;
        case (r_digit)
            DIG_ONES: begin
                w_nib         = r_active[3:0];
                w_an_sel      = 3'b110;
                w_digit_blank = 1'b0;
            end
            DIG_TENS: begin
                w_nib         = r_active[7:4];
                w_an_sel      = 3'b101;
                w_digit_blank = i_lz_blank && w_hund_zero && w_tens_zero;
            end
            DIG_HUNDS: begin
                w_nib         = r_active[11:8];
                w_an_sel      = 3'b011;
                w_digit_blank = i_lz_blank && w_hund_zero;
            end
            default: begin
                w_nib         = 4'd0;
                w_an_sel      = 3'b111;
                w_digit_blank = 1'b1;
            end
        endcase
    end

    // Next-output values. The first cycle of each slot is always dark.
    always_comb begin
        w_an_nxt  = 3'b111;
        w_seg_nxt = 7'h7F;
        if (w_slot_start || w_digit_blank) begin
            w_an_nxt  = 3'b111;
            w_seg_nxt = 7'h7F;
        end else begin
            w_an_nxt  = w_an_sel;
            w_seg_nxt = f_seg_encode(w_nib);
        end
    end

    // Output registers for the anode enables and segments.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_an  <= 3'b111;
            r_seg <= 7'h7F;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;
    assign o_err = r_err;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display with REFRESH_DIV=4 (12-cycle frames).
// The stimulus pushes hand-computed per-cycle expectations for each frame into
// a queue. A forked monitor pops one entry on every falling edge and compares.
module tb_bcd_scan_display;

    logic        clk;
    logic        rst;
    logic [11:0] bcd_in;
    logic        load;
    logic        lz_blank;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        err;

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    logic mon_en;
    int   n_checks;
    int   n_errors;

    bcd_scan_display #(.REFRESH_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_bcd_in   (bcd_in),
        .i_load     (load),
        .i_lz_blank (lz_blank),
        .o_an       (an),
        .o_seg      (seg),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_entry(input logic [2:0] a, input logic [6:0] s, input logic e);
        exp_t x;
        x.an  = a;
        x.seg = s;
        x.err = e;
        exp_q.push_back(x);
    endtask

    // Push the 12 expected cycles of one frame.
    // so/st/sh are the segment patterns; bt/bh mark tens/hundreds as blanked.
    task automatic push_frame(input logic [6:0] so, input logic [6:0] st, input logic [6:0] sh,
                              input logic bt, input logic bh, input logic e);
        push_entry(3'b111, 7'h7F, e);
        for (int i = 0; i < 3; i++) push_entry(3'b110, so, e);
        push_entry(3'b111, 7'h7F, e);
        for (int i = 0; i < 3; i++) push_entry(bt ? 3'b111 : 3'b101, bt ? 7'h7F : st, e);
        push_entry(3'b111, 7'h7F, e);
        for (int i = 0; i < 3; i++) push_entry(bh ? 3'b111 : 3'b011, bh ? 7'h7F : sh, e);
    endtask

    // Direct comparison of the outputs, used outside the scan monitor.
    task automatic check_out(input string name, input logic [2:0] ea, input logic [6:0] es, input logic ee);
        n_checks++;
        if (an !== ea || seg !== es || err !== ee) begin
            n_errors++;
            $display("FAIL %s: got an=%b seg=%h err=%b, expected an=%b seg=%h err=%b",
                     name, an, seg, err, ea, es, ee);
        end
    endtask

    // Run one frame; entered and left #1 after the frame-boundary clock edge.
    // Inputs change on falling edges. Cycle c of the frame is the c-th falling edge.
    // A load driven at c=12 is sampled on the next boundary edge.
    task automatic run_frame(input logic lda, input logic [11:0] va, input int ca,
                             input logic ldb, input logic [11:0] vb, input int cb,
                             input logic lz_next);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (lda && c == ca) begin
                load   = 1'b1;
                bcd_in = va;
            end
            if (ldb && c == cb) begin
                load   = 1'b1;
                bcd_in = vb;
            end
            if (c == 12) lz_blank = lz_next;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = 12'h000;
        lz_blank = 1'b0;

        // Scan monitor
        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL scan_underflow: got an=%b seg=%h err=%b, expected no output pending", an, seg, err);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (an !== e.an || seg !== e.seg || err !== e.err) begin
                            n_errors++;
                            $display("FAIL scan_check_%0d: got an=%b seg=%h err=%b, expected an=%b seg=%h err=%b",
                                     n_checks, an, seg, err, e.an, e.seg, e.err);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("reset_state", 3'b111, 7'h7F, 1'b0);
        rst = 1'b0;

        // F0: after reset, 000 with no blanking; load 079 mid-frame, which must not appear yet.
        push_frame(7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_frame(1'b1, 12'h079, 3, 1'b0, 12'h000, 0, 1'b1);

        // F1: 079 with lz: ones 9, tens 7, hundreds blank. Load 255 then 025.
        push_frame(7'h10, 7'h78, 7'h7F, 1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 12'h255, 3, 1'b1, 12'h025, 6, 1'b0);

        // F2: 025 with no lz: 0/2/5, and 255 never appears.
        push_frame(7'h12, 7'h24, 7'h40, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 12'h0A3, 3, 1'b0, 12'h000, 0, 1'b0);

        // F3: 0A3: tens shown as a dash, err set.
        push_frame(7'h30, 7'h3F, 7'h40, 1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 12'h123, 5, 1'b0, 12'h000, 0, 1'b1);

        // F4: 123 with lz: nothing blanked, err cleared.
        push_frame(7'h30, 7'h24, 7'h79, 1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 12'h000, 9, 1'b0, 12'h000, 0, 1'b1);

        // F5: 000 with lz: tens and hundreds blank. Load 0A3 on the boundary cycle.
        push_frame(7'h40, 7'h7F, 7'h7F, 1'b1, 1'b1, 1'b0);
        run_frame(1'b1, 12'h0A3, 12, 1'b0, 12'h000, 0, 1'b0);

        // F6: the boundary load is held back, so this frame still shows 000 (no lz).
        push_frame(7'h40, 7'h40, 7'h40, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 12'h000, 0, 1'b0, 12'h000, 0, 1'b1);

        // F7: 0A3 with lz: hundreds blank, tens A is not zero and shows a dash, err set.
        push_frame(7'h30, 7'h3F, 7'h7F, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (c == 3) begin
                load   = 1'b1;
                bcd_in = 12'h987;
            end
        end
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check_out("tens_before_rst", 3'b101, 7'h3F, 1'b1);
        rst = 1'b1;
        #1;
        check_out("async_rst", 3'b111, 7'h7F, 1'b0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // F8/F9: scan restarts at ones. The 987 pending load was discarded,
        // so the display shows 000 with lz.
        push_frame(7'h40, 7'h7F, 7'h7F, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        run_frame(1'b0, 12'h000, 0, 1'b0, 12'h000, 0, 1'b1);
        push_frame(7'h40, 7'h7F, 7'h7F, 1'b1, 1'b1, 1'b0);
        run_frame(1'b0, 12'h000, 0, 1'b0, 12'h000, 0, 1'b1);
        mon_en = 1'b0;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drained: got %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
